// File: rtl/sdp_mrdma_rd_req_arb.sv
// DMA read-request arbiter: round-robin grant among enabled sources, optional burst lock
// on one owner, and a single registered output stage with 1 beat/cycle throughput.
module sdp_mrdma_rd_req_arb #(
    parameter int unsigned NUM_REQ  = 3,
    parameter int unsigned PD_WIDTH = 79
) (
    input  logic                        nvdla_core_clk,
    input  logic                        nvdla_core_rst,
    input  logic [NUM_REQ-1:0]          req_vld,
    input  logic [NUM_REQ*PD_WIDTH-1:0] req_pd,
    output logic [NUM_REQ-1:0]          req_rdy,
    input  logic [3:0]                  cfg_burst_len,
    input  logic [NUM_REQ-1:0]          cfg_req_en,
    output logic                        dma_rd_req_vld,
    output logic [PD_WIDTH-1:0]         dma_rd_req_pd,
    output logic [1:0]                  dma_rd_req_src,
    input  logic                        dma_rd_req_rdy,
    output logic                        arb_idle
);

    localparam int unsigned IdW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic {StArb, StLock} state_e;

    state_e              r_state, w_state_d;
    logic [IdW-1:0]      r_own_id, w_own_id_d;
    logic [3:0]          r_beat_cnt, w_beat_cnt_d;
    logic [IdW-1:0]      r_rr_ptr, w_rr_ptr_d;
    logic                r_vld, w_vld_d;
    logic [PD_WIDTH-1:0] r_pd, w_pd_d;
    logic [1:0]          r_src, w_src_d;

    logic [3:0]          w_eff_len;
    logic                w_load_en;
    logic [NUM_REQ-1:0]  w_elig;
    logic                w_arb_found;
    logic [IdW-1:0]      w_arb_id;
    logic [IdW:0]        w_sum;
    logic                w_gnt;
    logic [IdW-1:0]      w_gnt_id;

    function automatic logic [IdW-1:0] inc_id(input logic [IdW-1:0] id);
        if (32'(id) + 32'd1 >= NUM_REQ) return '0;
        return id + IdW'(1);
    endfunction

    assign w_eff_len = (cfg_burst_len == 4'd0) ? 4'd1 : cfg_burst_len;
    assign w_load_en = !r_vld || dma_rd_req_rdy;
    assign w_elig    = req_vld & cfg_req_en;

    // First eligible source scanning cyclically upward from r_rr_ptr.
    always_comb begin
        w_arb_found = 1'b0;
        w_arb_id    = '0;
        w_sum       = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            w_sum = {1'b0, r_rr_ptr} + (IdW+1)'(k);
            if (w_sum >= (IdW+1)'(NUM_REQ)) w_sum = w_sum - (IdW+1)'(NUM_REQ);
            if (!w_arb_found && w_elig[w_sum[IdW-1:0]]) begin
                w_arb_found = 1'b1;
                w_arb_id    = w_sum[IdW-1:0];
            end
        end
    end

    always_comb begin
        w_state_d    = r_state;
        w_own_id_d   = r_own_id;
        w_beat_cnt_d = r_beat_cnt;
        w_rr_ptr_d   = r_rr_ptr;
        w_gnt        = 1'b0;
        w_gnt_id     = r_own_id;
        unique case (r_state)
            StArb: begin
                w_gnt_id = w_arb_id;
                if (w_arb_found && w_load_en) begin
                    w_gnt = 1'b1;
                    if (w_eff_len == 4'd1) begin
                        w_rr_ptr_d = inc_id(w_arb_id);
                    end else begin
                        w_state_d    = StLock;
                        w_own_id_d   = w_arb_id;
                        w_beat_cnt_d = 4'd1;
                    end
                end
            end
            StLock: begin
                // Owner dropped (disabled, or idle while the output could load): release.
                if (!cfg_req_en[r_own_id] || (w_load_en && !req_vld[r_own_id])) begin
                    w_state_d    = StArb;
                    w_rr_ptr_d   = inc_id(r_own_id);
                    w_beat_cnt_d = 4'd0;
                end else if (w_load_en) begin
                    w_gnt = 1'b1;
                    if ({1'b0, r_beat_cnt} + 5'd1 >= {1'b0, w_eff_len}) begin
                        w_state_d    = StArb;
                        w_rr_ptr_d   = inc_id(r_own_id);
                        w_beat_cnt_d = 4'd0;
                    end else begin
                        w_beat_cnt_d = r_beat_cnt + 4'd1;
                    end
                end
            end
            default: w_state_d = StArb;
        endcase
    end

    always_comb begin
        req_rdy = '0;
        if (w_gnt && !nvdla_core_rst) req_rdy[w_gnt_id] = 1'b1;
    end

    always_comb begin
        w_vld_d = r_vld;
        w_pd_d  = r_pd;
        w_src_d = r_src;
        if (w_gnt) begin
            w_vld_d = 1'b1;
            w_pd_d  = req_pd[32'(w_gnt_id)*PD_WIDTH +: PD_WIDTH];
            w_src_d = 2'(w_gnt_id);
        end else if (dma_rd_req_rdy) begin
            w_vld_d = 1'b0;
        end
    end

    always_ff @(posedge nvdla_core_clk) begin
        if (nvdla_core_rst) begin
            r_state    <= StArb;
            r_own_id   <= '0;
            r_beat_cnt <= 4'd0;
            r_rr_ptr   <= '0;
            r_vld      <= 1'b0;
            r_pd       <= '0;
            r_src      <= 2'd0;
        end else begin
            r_state    <= w_state_d;
            r_own_id   <= w_own_id_d;
            r_beat_cnt <= w_beat_cnt_d;
            r_rr_ptr   <= w_rr_ptr_d;
            r_vld      <= w_vld_d;
            r_pd       <= w_pd_d;
            r_src      <= w_src_d;
        end
    end

    assign dma_rd_req_vld = r_vld;
    assign dma_rd_req_pd  = r_pd;
    assign dma_rd_req_src = r_src;
    assign arb_idle       = (r_state == StArb) && !r_vld && !(|w_elig);

endmodule
